// File: rtl/buf_stream_ctrl.sv
// ---------------------------------------------------------------------------
// buf_stream_ctrl
//
// Streaming access controller for a single-port on-chip buffer with a
// 1-cycle registered read. One job either loads a valid/ready input stream
// into a contiguous address range (LOAD) or drains a contiguous range out
// as a valid/ready output stream (DRAIN).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_start/i_dir/i_base_addr/i_len   job request, sampled only in IDLE
//   o_busy, o_done              job status (done is a one-cycle pulse)
//   i_s_valid/o_s_ready/i_s_data      LOAD input stream
//   o_m_valid/i_m_ready/o_m_data      DRAIN output stream
//   o_buf_cen/o_buf_wen/o_buf_addr/o_buf_wdata   buffer port (wen 1 = write)
//   i_buf_rdata                 buffer read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module buf_stream_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_dir,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_len,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_buf_cen,
    output logic                  o_buf_wen,
    output logic [ADDR_WIDTH-1:0] o_buf_addr,
    output logic [DATA_WIDTH-1:0] o_buf_wdata,
    input  logic [DATA_WIDTH-1:0] i_buf_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr;        // next buffer address to access
    logic [ADDR_WIDTH-1:0] r_remain;      // accesses (writes or reads) still to issue
    logic [ADDR_WIDTH-1:0] r_out_remain;  // DRAIN words still to hand out
    logic [ADDR_WIDTH-1:0] r_addr_hold;   // buf_addr shown while idle
    logic [DATA_WIDTH-1:0] r_wdata_hold;  // buf_wdata shown while idle
    logic                  r_busy;
    logic                  r_inflight;    // a read was issued last cycle

    // 2-entry output FIFO for DRAIN
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_accept;
    logic                  w_write;
    logic                  w_read;
    logic                  w_access;
    logic                  w_pop;
    logic [2:0]            w_occupancy;

    assign o_m_valid   = (r_count != 2'd0);
    assign o_m_data    = r_fifo[r_rd_ptr];
    assign w_pop       = o_m_valid & i_m_ready;
    // FIFO words plus the word still coming back from the buffer
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};

    assign w_access    = w_write | w_read;
    assign o_buf_cen   = w_access;
    assign o_buf_wen   = w_write;
    assign o_buf_addr  = w_access ? r_addr : r_addr_hold;
    assign o_buf_wdata = w_write ? i_s_data : r_wdata_hold;
    assign o_busy      = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_write      = 1'b0;
        w_read       = 1'b0;
        o_s_ready    = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    if (i_len == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = i_dir ? ST_DRAIN : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                o_s_ready = 1'b1;
                w_write   = i_s_valid;
                if (i_s_valid && (r_remain == ONE_A)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DRAIN: begin
                // A slot freed by this cycle's pop may be reused immediately,
                // which keeps one word per cycle flowing with m_ready high.
                w_read = (r_remain != '0) &&
                         (w_occupancy < (3'd2 + {2'b00, w_pop}));
                if (w_pop && (r_out_remain == ONE_A)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_remain     <= '0;
            r_out_remain <= '0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
            r_busy       <= 1'b0;
            r_inflight   <= 1'b0;
            r_fifo[0]    <= '0;
            r_fifo[1]    <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
        end else begin
            if (w_accept) begin
                r_addr       <= i_base_addr;
                r_remain     <= i_len;
                r_out_remain <= i_len;
                r_busy       <= (i_len != '0);
            end else begin
                if (w_access) begin
                    r_addr      <= r_addr + ONE_A;
                    r_remain    <= r_remain - ONE_A;
                    r_addr_hold <= r_addr;
                end
                if (w_pop) begin
                    r_out_remain <= r_out_remain - ONE_A;
                end
                if (r_state == ST_DONE) begin
                    r_busy <= 1'b0;
                end
            end

            if (w_write) begin
                r_wdata_hold <= i_s_data;
            end

            r_inflight <= w_read;

            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= i_buf_rdata;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_buf_stream_ctrl.sv
`timescale 1ns/1ps
// Testbench for buf_stream_ctrl: randomized and directed jobs, a buffer
// model, a reference memory image and a scoreboard monitor.
module tb_buf_stream_ctrl;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          buf_cen;
    logic          buf_wen;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_wdata;
    logic [DW-1:0] buf_rdata;

    always #5 clk = ~clk;

    buf_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_dir       (dir),
        .i_base_addr (base_addr),
        .i_len       (len),
        .o_busy      (busy),
        .o_done      (done),
        .i_s_valid   (s_valid),
        .o_s_ready   (s_ready),
        .i_s_data    (s_data),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_data    (m_data),
        .o_buf_cen   (buf_cen),
        .o_buf_wen   (buf_wen),
        .o_buf_addr  (buf_addr),
        .o_buf_wdata (buf_wdata),
        .i_buf_rdata (buf_rdata)
    );

    // Buffer model: single port, registered read
    logic [DW-1:0] mem     [0:65535];
    // Reference image of what the buffer should hold
    logic [DW-1:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (buf_cen) begin
            if (buf_wen) mem[buf_addr] = buf_wdata;
            else         buf_rdata <= mem[buf_addr];
        end
    end

    // Scoreboard queues
    logic [31:0]   exp_wr[$];   // {addr, data}
    logic [AW-1:0] exp_rd[$];
    logic [DW-1:0] exp_m[$];

    int  total = 0;
    int  bad   = 0;
    bit  job_open = 1'b0;
    int  outst = 0;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a transaction
    always @(negedge clk) begin
        logic [31:0]   ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] em;
        if (!rst_n) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("m_hold_valid", m_valid, 1);
                chk("m_hold_data", m_data, prev_data);
            end
            if (buf_cen && buf_wen) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write addr=%h data=%h required=no write", buf_addr, buf_wdata);
                end else begin
                    ew = exp_wr.pop_front();
                    chk("write_addr", buf_addr, ew[31:16]);
                    chk("write_data", buf_wdata, ew[15:0]);
                end
            end
            if (buf_cen && !buf_wen) begin
                outst++;
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_read addr=%h required=no read", buf_addr);
                end else begin
                    ea = exp_rd.pop_front();
                    chk("read_addr", buf_addr, ea);
                end
            end
            if (m_valid && m_ready) begin
                outst--;
                if (exp_m.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_m_word data=%h required=no word", m_data);
                end else begin
                    em = exp_m.pop_front();
                    chk("m_data", m_data, em);
                end
            end
            if (buf_cen && !buf_wen) chk("reads_outstanding_le2", (outst <= 2), 1);
            if (done) begin
                chk("done_expected", job_open, 1);
                job_open = 1'b0;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_buf_cen"}, buf_cen, 0);
        chk({tag, "_buf_wen"}, buf_wen, 0);
        chk({tag, "_buf_addr"}, buf_addr, 0);
        chk({tag, "_buf_wdata"}, buf_wdata, 0);
    endtask

    task automatic clear_expect();
        exp_wr.delete();
        exp_rd.delete();
        exp_m.delete();
        job_open = 1'b0;
    endtask

    task automatic recover_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        clear_expect();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_job(input bit d, input logic [AW-1:0] b, input logic [AW-1:0] n);
        @(posedge clk); #1;
        job_open  = 1'b1;
        start     = 1'b1;
        dir       = d;
        base_addr = b;
        len       = n;
    endtask

    // Common end-of-job checks, run in the done cycle
    task automatic after_done(input string kind, input logic [AW-1:0] b,
                              input int n, input int cyc);
        chk("busy_at_done", busy, (n != 0));
        $display("job %s base=%h len=%0d done_cycle=%0d", kind, b, n, cyc);
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic run_load(input logic [AW-1:0] b, input int n, input int mode,
                            input bit fixed, input int junk_cyc);
        logic [DW-1:0] words[$];
        logic [DW-1:0] w;
        logic [AW-1:0] a;
        int cyc, idx, bound;
        bit got_done;
        for (int i = 0; i < n; i++) begin
            w = fixed ? DW'(16'h00A0 + i) : DW'($urandom);
            a = b + AW'(i);
            words.push_back(w);
            ref_mem[a] = w;
            exp_wr.push_back({a, w});
        end
        start_job(1'b0, b, AW'(n));
        cyc = 0; idx = 0; bound = 8 * n + 40; got_done = 1'b0;
        while (cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
            start     = (cyc == junk_cyc);
            dir       = 1'($urandom_range(0, 1));
            base_addr = AW'($urandom);
            len       = AW'($urandom_range(1, 5));
            s_valid   = (idx < n) && ((mode == 0) || ($urandom_range(0, 1) == 1));
            s_data    = s_valid ? words[idx] : DW'($urandom);
            @(negedge clk);
            if (cyc == 1) chk("busy_cycle1", busy, (n != 0));
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (s_valid && s_ready) idx++;
        end
        if (!got_done) begin
            total++; bad++;
            $display("FAIL load_timeout cycles=%0d required=done", cyc);
            recover_reset();
        end else begin
            if (mode == 0) chk("load_done_cycle", cyc, (n == 0) ? 1 : n + 1);
            chk("writes_left", exp_wr.size(), 0);
            after_done("load", b, n, cyc);
        end
    endtask

    task automatic run_drain(input logic [AW-1:0] b, input int n, input int mode,
                             input int junk_cyc, input int abort_cyc);
        logic [AW-1:0] a;
        int cyc, bound;
        bit got_done, aborted;
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            exp_m.push_back(ref_mem[a]);
            exp_rd.push_back(a);
        end
        start_job(1'b1, b, AW'(n));
        cyc = 0; bound = 8 * n + 40; got_done = 1'b0; aborted = 1'b0;
        while (cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
            start     = (cyc == junk_cyc);
            dir       = 1'($urandom_range(0, 1));
            base_addr = AW'($urandom);
            len       = AW'($urandom_range(1, 5));
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc >= 6 && cyc <= 10) ? 1'b0 : cyc[0];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                #2;
                rst_n = 1'b0;
                start = 1'b0;
                m_ready = 1'b0;
                clear_expect();
                #1;
                check_all_zero("abort");
                repeat (3) begin
                    @(negedge clk);
                    chk("no_done_after_abort", done, 0);
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
                aborted = 1'b1;
                $display("job drain base=%h len=%0d aborted_cycle=%0d", b, n, cyc);
                break;
            end
            @(negedge clk);
            if (cyc == 1) chk("busy_cycle1", busy, (n != 0));
            if (mode == 0 && cyc >= 3 && cyc <= n + 2) chk("m_valid_streaming", m_valid, 1);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            if (!got_done) begin
                total++; bad++;
                $display("FAIL drain_timeout cycles=%0d required=done", cyc);
                recover_reset();
            end else begin
                if (mode == 0) chk("drain_done_cycle", cyc, (n == 0) ? 1 : n + 3);
                chk("words_left", exp_m.size(), 0);
                chk("reads_left", exp_rd.size(), 0);
                after_done("drain", b, n, cyc);
            end
        end
    endtask

    initial begin
        logic [AW-1:0] rb;
        int rn;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = DW'(i) ^ 16'h5A5A;
            ref_mem[i] = DW'(i) ^ 16'h5A5A;
        end
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        run_load(16'h0010, 4, 0, 1'b1, 0);
        run_drain(16'h0010, 4, 0, 0, 0);
        run_drain(16'h0400, 8, 0, 0, 0);
        run_drain(16'h0800, 6, 1, 0, 0);
        run_load(16'hFFFE, 4, 0, 1'b0, 0);
        run_drain(16'hFFFE, 4, 0, 0, 0);
        run_load(16'h0020, 0, 0, 1'b0, 0);
        run_drain(16'h0030, 0, 0, 0, 0);
        run_load(16'h0200, 4, 0, 1'b0, 2);
        run_drain(16'h0200, 4, 0, 3, 0);

        for (int k = 0; k < 12; k++) begin
            rb = AW'($urandom);
            if (k % 4 == 0) rb = 16'hFFF8 + AW'($urandom_range(0, 7));
            rn = $urandom_range(0, 12);
            if ($urandom_range(0, 1) == 1) run_drain(rb, rn, 2, 0, 0);
            else                           run_load(rb, rn, 1, 1'b0, 0);
        end

        run_drain(16'h0300, 10, 0, 0, 5);
        run_drain(16'h0010, 4, 0, 0, 0);
        run_load(16'h0050, 3, 1, 1'b0, 0);
        run_drain(16'h0050, 3, 2, 0, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/buf_stream_ctrl.md
# buf_stream_ctrl

Streaming access controller for the single-port on-chip buffer (cen/wen/addr/wdata/rdata, 1-cycle registered read). It drives the buffer's port as the initiator: one job either loads a valid/ready input stream into a contiguous address range (LOAD) or drains a contiguous range out as a valid/ready output stream (DRAIN). It sits between the DMA/stream fabric and each buffer instance in the accelerator datapath.

## Interface
- ADDR_WIDTH, 16, buffer address width; job length counter has the same width
- DATA_WIDTH, 16, word width of streams and buffer

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job request; sampled only in IDLE
- dir  in  1  0 = LOAD (stream -> buffer), 1 = DRAIN (buffer -> stream); sampled with start
- base_addr  in  ADDR_WIDTH  first buffer address; sampled with start
- len  in  ADDR_WIDTH  word count; 0 = empty job; sampled with start
- busy  out  1  high from the cycle after start acceptance until DONE exits
- done  out  1  one-cycle completion pulse
- s_valid / s_ready / s_data  in / out / in  1 / 1 / DATA_WIDTH  LOAD input stream
- m_valid / m_ready / m_data  out / in / out  1 / 1 / DATA_WIDTH  DRAIN output stream
- buf_cen / buf_wen / buf_addr / buf_wdata  out  1 / 1 / ADDR_WIDTH / DATA_WIDTH  buffer port (wen 1 = write, 0 = read)
- buf_rdata  in  DATA_WIDTH  buffer read data, valid the cycle after a read strobe

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE -> LOAD/DRAIN: start=1 and len!=0.
  - IDLE -> DONE: start=1 and len=0. No buffer access occurs.
  - LOAD -> DONE: final write issued.
  - DRAIN -> DONE: final m handshake.
  - DONE -> IDLE: unconditional; done=1 only in DONE.
- start is ignored outside IDLE; base_addr, dir and len are latched at acceptance.
- Address counter starts at base_addr and increments by 1 per issued access. It wraps modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000 at default width).
- LOAD:
  - s_ready=1 for the whole state.
  - On each s handshake: buf_cen=buf_wen=1, buf_wdata=s_data, buf_addr=counter.
  - Remaining count decrements per write.
  - s_valid low -> buf_cen=0 that cycle.
- DRAIN:
  - Reads are issued with buf_cen=1, buf_wen=0.
  - Returned words go into a 2-entry output FIFO; m_valid = FIFO non-empty, m_data = FIFO head.
  - A read issues when reads remain and (fifo_count + reads_in_flight − pop_this_cycle) < 2. This prevents overflow and sustains 1 word/cycle with m_ready held high.
  - m_ready low holds m_data/m_valid stable and stalls reads once the FIFO is full.
- Outside an active access: buf_cen=0, buf_wen=0, and buf_addr/buf_wdata hold their last values.
- Reset (including mid-job) immediately aborts:
  - state=IDLE, FIFO emptied, counters 0.
  - All outputs 0: busy, done, s_ready, m_valid, m_data, buf_cen, buf_wen, buf_addr, buf_wdata.
  - No done pulse for an aborted job.

## Timing
- Cycle 0: start accepted. Cycle 1: state LOAD/DRAIN, busy=1.
- LOAD:
  - Writes occur in the same cycle as the s handshake; buf_cen and buf_wen are combinational from s_valid in LOAD.
  - done is asserted the cycle after the last write.
- DRAIN:
  - First read in cycle 1; buf_rdata valid in cycle 2 and captured into the FIFO at the end of cycle 2.
  - First m_valid in cycle 3.
  - With m_ready=1 throughout, words leave in cycles 3..len+2, done in cycle len+3, IDLE in cycle len+4.
- len=0: done in cycle 1, busy=0 throughout.
- busy falls the cycle after done. A new start can be accepted the cycle after done.

## Test plan
- LOAD base=0x0010, len=4, s_data 0xA0..0xA3 with s_valid held high -> writes to 0x10..0x13 in cycles 1..4, done in cycle 5, and a subsequent DRAIN returns 0xA0..0xA3 in order.
- DRAIN len=8 with m_ready=1 -> m_valid continuous for cycles 3..10, 8 words in order, done in cycle 11, never more than 2 reads outstanding.
- DRAIN len=6 with m_ready toggling 1010… and one 5-cycle low stretch -> m_data stable while stalled, no loss or duplication, buf_cen=0 while the FIFO is full.
- LOAD base=0xFFFE, len=4 -> buf_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; also len=0 -> done in cycle 1 and buf_cen never asserted.
- start pulsed during an active job is ignored. rst_n asserted mid-DRAIN -> all outputs 0 asynchronously, no done pulse, and a fresh job after release runs correctly.
